// File: rtl/full_subtractor_3.sv
// Registered ripple-borrow subtractor: {B, D} = X - Y - Z, one-cycle latency.
// D/B load only on accepted inputs and otherwise keep their last result;
// out_valid follows in_valid by one cycle. rst clears everything asynchronously.
module full_subtractor_3 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] D,
  output logic             B,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Z,
  input  logic             in_valid,
  output logic             out_valid
);

  // Bit-serial borrow chain, LSB first; returns {borrow_out, difference}.
  function automatic logic [WIDTH:0] ripple_sub(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic             borrow_in
  );
    logic             b;
    logic [WIDTH-1:0] d;
    b = borrow_in;
    d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      d[i] = x[i] ^ y[i] ^ b;
      b    = (~x[i] & y[i]) | (~x[i] & b) | (y[i] & b);
    end
    return {b, d};
  endfunction

  logic [WIDTH-1:0] diff_s;
  logic             borrow_s;

  // Combinational difference and final borrow for the current operands.
  always_comb begin
    diff_s   = '0;
    borrow_s = 1'b0;
    {borrow_s, diff_s} = ripple_sub(X, Y, Z);
  end

  // Result registers: capture on valid input, hold otherwise; valid is a plain delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D         <= '0;
      B         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        D <= diff_s;
        B <= borrow_s;
      end else begin
        D <= D;
        B <= B;
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor_3.sv
// Directed and random checks for full_subtractor_3 at WIDTH=1 and WIDTH=8.
module tb_full_subtractor_3;

  logic       clk;
  logic       rst;

  logic [7:0] x8, y8, d8;
  logic       z8, v8, b8, ov8;

  logic [0:0] x1, y1, d1;
  logic       z1, v1, b1, ov1;

  int checks;
  int errors;

  logic [1:0] tt [8];
  logic [7:0] exp_d;
  logic       exp_b;
  logic [8:0] ref_r;

  full_subtractor_3 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .D(d8), .B(b8), .X(x8), .Y(y8), .Z(z8),
    .in_valid(v8), .out_valid(ov8)
  );

  full_subtractor_3 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .D(d1), .B(b1), .X(x1), .Y(y1), .Z(z1),
    .in_valid(v1), .out_valid(ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic z, input logic v);
    x8 = x; y8 = y; z8 = z; v8 = v;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tt = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    rst = 1'b0;
    drive8(8'h05, 8'h03, 1'b1, 1'b1);
    x1 = 1'b1; y1 = 1'b0; z1 = 1'b0; v1 = 1'b1;

    // Reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    check_val("rst_d", {56'd0, d8}, 64'd0);
    check_val("rst_b", {63'd0, b8}, 64'd0);
    check_val("rst_ov", {63'd0, ov8}, 64'd0);
    tick();
    check_val("rst_edge_ov", {63'd0, ov8}, 64'd0);
    check_val("rst_edge_d", {56'd0, d8}, 64'd0);
    rst = 1'b0;
    drive8(8'h00, 8'h00, 1'b0, 1'b0);
    v1 = 1'b0;
    tick();
    check_val("post_rst_idle_ov", {63'd0, ov8}, 64'd0);

    // WIDTH=1 truth table, XYZ = 000..111.
    for (int i = 0; i < 8; i++) begin
      {x1, y1, z1} = i[2:0];
      v1 = 1'b1;
      tick();
      check_val($sformatf("tt%0d_db", i), {62'd0, d1, b1}, {62'd0, tt[i]});
      check_val($sformatf("tt%0d_ov", i), {63'd0, ov1}, 64'd1);
    end
    v1 = 1'b0;

    // WIDTH=8 directed vectors, back-to-back.
    drive8(8'h05, 8'h03, 1'b1, 1'b1); tick();
    check_val("v1_d", {56'd0, d8}, 64'h01);
    check_val("v1_b", {63'd0, b8}, 64'd0);
    check_val("v1_ov", {63'd0, ov8}, 64'd1);
    drive8(8'h00, 8'h00, 1'b1, 1'b1); tick();
    check_val("wrap_d", {56'd0, d8}, 64'hFF);
    check_val("wrap_b", {63'd0, b8}, 64'd1);
    drive8(8'hFF, 8'hFF, 1'b1, 1'b1); tick();
    check_val("ones_d", {56'd0, d8}, 64'hFF);
    check_val("ones_b", {63'd0, b8}, 64'd1);
    drive8(8'h5A, 8'h5A, 1'b0, 1'b1); tick();
    check_val("eq_d", {56'd0, d8}, 64'h00);
    check_val("eq_b", {63'd0, b8}, 64'd0);

    // Hold: result 01 stays while in_valid is low.
    drive8(8'h05, 8'h03, 1'b1, 1'b1); tick();
    check_val("hold_pre_d", {56'd0, d8}, 64'h01);
    for (int i = 0; i < 3; i++) begin
      drive8(8'hAA + 8'(i), 8'h11, 1'b1, 1'b0); tick();
      check_val($sformatf("hold%0d_d", i), {56'd0, d8}, 64'h01);
      check_val($sformatf("hold%0d_b", i), {63'd0, b8}, 64'd0);
      check_val($sformatf("hold%0d_ov", i), {63'd0, ov8}, 64'd0);
    end

    // Mid-cycle asynchronous reset with a non-zero result held.
    drive8(8'h80, 8'h01, 1'b0, 1'b1); tick();
    check_val("pre_arst_d", {56'd0, d8}, 64'h7F);
    check_val("pre_arst_ov", {63'd0, ov8}, 64'd1);
    rst = 1'b1;
    #1;
    check_val("arst_d", {56'd0, d8}, 64'd0);
    check_val("arst_b", {63'd0, b8}, 64'd0);
    check_val("arst_ov", {63'd0, ov8}, 64'd0);
    #1 rst = 1'b0;
    drive8(8'h33, 8'h44, 1'b0, 1'b0); tick();
    check_val("after_arst_ov", {63'd0, ov8}, 64'd0);
    check_val("after_arst_d", {56'd0, d8}, 64'd0);
    drive8(8'h10, 8'h20, 1'b0, 1'b1); tick();
    check_val("first_after_d", {56'd0, d8}, 64'hF0);
    check_val("first_after_b", {63'd0, b8}, 64'd1);
    check_val("first_after_ov", {63'd0, ov8}, 64'd1);

    // Random stream against the arithmetic reference.
    exp_d = 8'hF0;
    exp_b = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] rx, ry;
      logic       rz, rv;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 255));
      rz = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      drive8(rx, ry, rz, rv);
      tick();
      if (rv) begin
        ref_r = {1'b0, rx} - {1'b0, ry} - {8'd0, rz};
        exp_d = ref_r[7:0];
        exp_b = ref_r[8];
      end
      check_val("rnd_ov", {63'd0, ov8}, {63'd0, rv});
      check_val("rnd_d", {56'd0, d8}, {56'd0, exp_d});
      check_val("rnd_b", {63'd0, b8}, {63'd0, exp_b});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_subtractor_3.md
FULL_SUBTRACTOR_3 -- requirements
Module: full_subtractor_3

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits for X, Y and D; legal range 1..64.
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: D  output  WIDTH  registered difference, X - Y - Z modulo 2^WIDTH.
REQ-005 Port: B  output  1  registered borrow-out; 1 when X < Y + Z as unsigned values.
REQ-006 Port: X  input  WIDTH  minuend, unsigned.
REQ-007 Port: Y  input  WIDTH  subtrahend, unsigned.
REQ-008 Port: Z  input  1  borrow-in.
REQ-009 Port: in_valid  input  1  X/Y/Z qualify this cycle.
REQ-010 Port: out_valid  output  1  D/B hold a result computed from a valid input.
REQ-011 Positional port order: clk, rst, D, B, X, Y, Z, in_valid, out_valid.

Function
REQ-012 Per bit i, with b0 = Z: D[i] = X[i] ^ Y[i] ^ b_i; b_(i+1) = (~X[i] & Y[i]) | (~X[i] & b_i) | (Y[i] & b_i); the ripple chain is purely combinational.
REQ-013 B equals b_WIDTH, the final borrow.
REQ-014 Equivalent arithmetic: {B, D} = ({1'b0, X} - {1'b0, Y} - Z) taken in WIDTH+1 bits, two's complement, with B = MSB.
REQ-015 Latency is exactly 1 clk cycle: on each rising edge with in_valid = 1, D and B register the result for the X/Y/Z present before that edge.
REQ-016 On a rising edge with in_valid = 0, D and B hold their previous values.
REQ-017 out_valid registers in_valid on every rising edge, so it is high in the cycle after each accepted input.
REQ-018 Back-to-back valid inputs produce one result per cycle; there is no backpressure and no stall.
REQ-019 Boundary X = Y and Z = 0 yields D = 0, B = 0.
REQ-020 Boundary X = 0, Y = 0, Z = 1 yields D = all ones, B = 1 (wrap-around).
REQ-021 Boundary X = all ones, Y = all ones, Z = 1 yields D = all ones, B = 1.
REQ-022 X, Y and Z that are X-valued are outside scope; the design is not required to propagate them.

Reset
REQ-023 While rst = 1, D = 0, B = 0 and out_valid = 0 immediately, independent of clk.
REQ-024 After rst deasserts, the first rising edge with in_valid = 1 produces a result on the following cycle.
REQ-025 Reset asserted mid-operation discards any in-flight result; out_valid stays 0 until a new valid input is accepted after release.

Verification
REQ-026 WIDTH=1 truth table, in_valid=1 each cycle, XYZ = 000..111 in order -> one cycle later {D,B} = 00, 11, 11, 01, 10, 00, 00, 11.
REQ-027 WIDTH=8, X=8'h05, Y=8'h03, Z=1 -> D=8'h01, B=0; then X=8'h00, Y=8'h00, Z=1 -> D=8'hFF, B=1.
REQ-028 Valid hold: result D=8'h01 registered, then in_valid=0 with new operands for 3 cycles -> D=8'h01 and B=0 unchanged, out_valid=0.
REQ-029 Async reset: assert rst between clock edges while D is non-zero -> D=0, B=0, out_valid=0 before the next edge.
REQ-030 Random WIDTH=8 stream, 1000 vectors with random in_valid -> every out_valid cycle matches the REQ-014 reference model.
